// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: byte FIFO in front of a serial shifter.
// Baud timing is derived internally from CLK_RATE / BAUD_RATE.
module uart_tx_buffered #(
  parameter int CLK_RATE   = 9600000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    data_in,
  input  logic                          wr_en,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          tx_busy,
  output logic                          RsTx
);

  localparam int BIT_CYCLES = CLK_RATE / BAUD_RATE;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;

  logic          push;
  logic          pop;
  logic          bit_done;
  logic          has_data;
  logic [7:0]    head;

  assign full     = (count_q == CNT_FULL);
  assign push     = wr_en & ~full;
  assign has_data = (count_q != '0);
  assign head     = mem_q[rptr_q];
  assign bit_done = (cyc_q == CYC_LAST);

  assign fifo_count = count_q;
  assign overflow   = ovf_q;
  assign tx_busy    = (state_q != IDLE);
  assign RsTx       = tx_q;

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        cyc_d = '0;
        tx_d  = 1'b1;
        if (has_data) begin
          pop     = 1'b1;
          shift_d = head;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (bit_done) begin
          cyc_d   = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          cyc_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          cyc_d = '0;
          // Chain straight into the next start bit when more bytes wait.
          if (has_data) begin
            pop     = 1'b1;
            shift_d = head;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q | (wr_en & full);
    if (push) begin
      wptr_d = wptr_q + AW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wptr_q] <= data_in;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: frame tables, corner
// sequences and a serial-decoding monitor fed by an expected-byte queue.
module tb_uart_tx_buffered;

  localparam int BITC  = 16;
  localparam int FRAME = 160;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       full;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       tx_busy;
  logic       RsTx;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  byte unsigned sb[$];
  int starts_q[$];

  typedef struct {
    logic [7:0] din;
    logic [9:0] frame;
  } vec_t;
  vec_t vt[5];

  uart_tx_buffered #(
    .CLK_RATE(16),
    .BAUD_RATE(1),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data_in(data_in),
    .wr_en(wr_en),
    .full(full),
    .fifo_count(fifo_count),
    .overflow(overflow),
    .tx_busy(tx_busy),
    .RsTx(RsTx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Serial receiver: samples each bit in its middle.
  int mstate = 0;
  int mcyc = 0;
  logic [7:0] mbyte = 8'h00;
  always @(negedge clk) begin
    int b;
    if (rst) begin
      mstate = 0;
    end else if (mstate == 0) begin
      if (RsTx == 1'b0) begin
        mstate = 1;
        mcyc = 0;
        starts_q.push_back(cyc);
      end
    end else begin
      mcyc++;
      if (mcyc % BITC == BITC / 2) begin
        b = mcyc / BITC;
        if (b == 0) begin
          check("mon_start_bit", int'(RsTx), 0);
        end else if (b <= 8) begin
          mbyte[b-1] = RsTx;
        end else begin
          check("mon_stop_bit", int'(RsTx), 1);
          check("mon_byte_expected", int'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            check("mon_byte", int'(mbyte), int'(sb.pop_front()));
          end
          mstate = 0;
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((tx_busy || fifo_count != 0) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", int'(n < 4000), 1);
    repeat (4) @(negedge clk);
    check("sb_drained", sb.size(), 0);
  endtask

  task automatic wr_one(input logic [7:0] d, input bit expect_sent);
    @(negedge clk);
    data_in = d;
    wr_en = 1'b1;
    if (expect_sent) sb.push_back(d);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{8'hA5, 10'b1_10100101_0};
    vt[1] = '{8'h00, 10'b1_00000000_0};
    vt[2] = '{8'hFF, 10'b1_11111111_0};
    vt[3] = '{8'h3C, 10'b1_00111100_0};
    vt[4] = '{8'h81, 10'b1_10000001_0};

    repeat (3) @(negedge clk);
    check("rst_RsTx", int'(RsTx), 1);
    check("rst_busy", int'(tx_busy), 0);
    check("rst_count", int'(fifo_count), 0);
    check("rst_full", int'(full), 0);
    check("rst_overflow", int'(overflow), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Cycle-exact single frames from idle.
    for (int i = 0; i < 5; i++) begin
      wr_one(vt[i].din, 1'b1);
      @(negedge clk);
      wr_en = 1'b0;
      check("vec_count_after_wr", int'(fifo_count), 1);
      check("vec_idle_line", int'(RsTx), 1);
      check("vec_idle_busy", int'(tx_busy), 0);
      for (int j = 1; j <= FRAME; j++) begin
        @(negedge clk);
        check("vec_line", int'(RsTx), int'(vt[i].frame[(j-1)/BITC]));
        check("vec_busy", int'(tx_busy), 1);
        if (j == 1) check("vec_count_popped", int'(fifo_count), 0);
      end
      @(negedge clk);
      check("vec_busy_drop", int'(tx_busy), 0);
      check("vec_line_idle", int'(RsTx), 1);
      wait_idle();
    end

    // Back-to-back frames with no idle gap.
    starts_q.delete();
    for (int i = 1; i <= 3; i++) wr_one(8'(i), 1'b1);
    @(negedge clk);
    wr_en = 1'b0;
    wait_idle();
    check("b2b_frames", starts_q.size(), 3);
    if (starts_q.size() == 3) begin
      check("b2b_gap1", starts_q[1] - starts_q[0], FRAME);
      check("b2b_gap2", starts_q[2] - starts_q[1], FRAME);
    end

    // Overflow: sixth byte dropped.
    for (int i = 0; i < 6; i++) wr_one(8'(8'h10 + i), i < 5);
    @(negedge clk);
    wr_en = 1'b0;
    check("ovf_full", int'(full), 1);
    check("ovf_count", int'(fifo_count), 4);
    check("ovf_flag", int'(overflow), 1);
    wait_idle();
    check("ovf_sticky", int'(overflow), 1);

    // Write coincident with STOP-to-START pop.
    for (int i = 0; i < 3; i++) wr_one(8'(8'h21 + i), 1'b1);
    @(negedge clk);
    wr_en = 1'b0;
    repeat (FRAME - 2) @(negedge clk);
    check("coinc_count_pre", int'(fifo_count), 2);
    check("coinc_stop_line", int'(RsTx), 1);
    data_in = 8'h24;
    wr_en = 1'b1;
    sb.push_back(8'h24);
    @(negedge clk);
    wr_en = 1'b0;
    check("coinc_count_post", int'(fifo_count), 2);
    check("coinc_start_line", int'(RsTx), 0);
    wait_idle();

    // Reset in the middle of data bit 3.
    wr_one(8'h55, 1'b0);
    wr_one(8'h66, 1'b0);
    @(negedge clk);
    wr_en = 1'b0;
    repeat (68) @(negedge clk);
    check("mid_bit3_line", int'(RsTx), 0);
    check("mid_count", int'(fifo_count), 1);
    rst = 1'b1;
    wr_en = 1'b1;
    data_in = 8'h99;
    @(negedge clk);
    check("rst_mid_line", int'(RsTx), 1);
    check("rst_mid_count", int'(fifo_count), 0);
    check("rst_mid_busy", int'(tx_busy), 0);
    check("rst_mid_ovf", int'(overflow), 0);
    @(negedge clk);
    check("rst_wr_ignored", int'(fifo_count), 0);
    rst = 1'b0;
    wr_en = 1'b0;
    @(negedge clk);
    check("rst_release_count", int'(fifo_count), 0);
    check("rst_release_busy", int'(tx_busy), 0);
    wr_one(8'h3C, 1'b1);
    @(negedge clk);
    wr_en = 1'b0;
    wait_idle();

    // Pointer wrap: ten bytes, written only while not full.
    begin
      int i = 0;
      int guard = 0;
      while (i < 10 && guard < 3000) begin
        @(negedge clk);
        guard++;
        if (!full) begin
          data_in = 8'(i);
          wr_en = 1'b1;
          sb.push_back(8'(i));
          i++;
        end else begin
          wr_en = 1'b0;
        end
      end
      check("wrap_all_written", i, 10);
    end
    @(negedge clk);
    wr_en = 1'b0;
    wait_idle();
    check("wrap_overflow", int'(overflow), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
